// File: rtl/dcr_pkg.sv
// Shared constants and types for the MEM stage and its data RAM.
package dcr_pkg;

    localparam int unsigned DMEM_DEPTH = 256;

    localparam logic [7:0] IO_PORT_ADDR   = 8'hFF;
    localparam logic [7:0] CYCLE_CNT_ADDR = 8'hFE;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  dmem_addr_t;

    // Source of the WB load data: the RAM read port or the captured register value.
    typedef enum logic {
        RdRam,
        RdReg
    } rd_sel_e;

endpackage

// File: rtl/dcr_memory_if.sv
// EXE/MEM-to-WB signal bundle for the MEM stage.
interface dcr_memory_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  clken;
    logic [DATA_WIDTH-1:0] ALUResultInMEM;
    logic [ADDR_WIDTH-1:0] ALUAddrInMEM;
    logic [DATA_WIDTH-1:0] RofRtInMEM;
    logic                  MemWriteInMEM;
    logic                  MemToRegInMEM;
    logic                  RegWriteInMEM;
    logic [4:0]            WriteRegInMEM;

    logic [DATA_WIDTH-1:0] MEMMEMBypassDataOutEXE;
    logic [DATA_WIDTH-1:0] ALUResultOutWB;
    logic [DATA_WIDTH-1:0] MemDataOutWB;
    logic                  MemToRegOutWB;
    logic                  RegWriteOutWB;
    logic [4:0]            WriteRegOutWB;
    logic [DATA_WIDTH-1:0] IOPortOut;
    logic [DATA_WIDTH-1:0] CycleCountOut;

    modport master (
        output clken, ALUResultInMEM, ALUAddrInMEM, RofRtInMEM,
               MemWriteInMEM, MemToRegInMEM, RegWriteInMEM, WriteRegInMEM,
        input  MEMMEMBypassDataOutEXE, ALUResultOutWB, MemDataOutWB, MemToRegOutWB,
               RegWriteOutWB, WriteRegOutWB, IOPortOut, CycleCountOut
    );

    modport slave (
        input  clken, ALUResultInMEM, ALUAddrInMEM, RofRtInMEM,
               MemWriteInMEM, MemToRegInMEM, RegWriteInMEM, WriteRegInMEM,
        output MEMMEMBypassDataOutEXE, ALUResultOutWB, MemDataOutWB, MemToRegOutWB,
               RegWriteOutWB, WriteRegOutWB, IOPortOut, CycleCountOut
    );

endinterface

// File: rtl/dcr_dmem.sv
// Single-port synchronous data RAM, read-before-write, array not reset.
module dcr_dmem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Read samples the old contents; a same-edge write lands afterwards.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dcr_memory.sv
// MEM pipeline stage: data RAM access, IO port and cycle counter registers, WB registers.
module dcr_memory
    import dcr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    dcr_memory_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] IoAddr  = ADDR_WIDTH'(IO_PORT_ADDR);
    localparam logic [ADDR_WIDTH-1:0] CntAddr = ADDR_WIDTH'(CYCLE_CNT_ADDR);

    logic                  is_io;
    logic                  is_cnt;
    logic                  is_ram;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] io_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic                  mtr_q;
    logic                  rw_q;
    logic [4:0]            wreg_q;
    rd_sel_e               rd_sel_q;
    logic [DATA_WIDTH-1:0] reg_rdata_q;
    logic [DATA_WIDTH-1:0] mem_data;

    // Address decode and RAM strobes; the write is gated by rst so a store
    // coinciding with reset is dropped.
    always_comb begin
        is_io  = (bus.ALUAddrInMEM == IoAddr);
        is_cnt = (bus.ALUAddrInMEM == CntAddr);
        is_ram = !is_io && !is_cnt;
        ram_we = bus.clken && bus.MemWriteInMEM && is_ram && !rst;
        ram_re = bus.clken && is_ram;
    end

    dcr_dmem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_dmem (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (bus.ALUAddrInMEM),
        .wdata(bus.RofRtInMEM),
        .rdata(ram_rdata)
    );

    // Free-running cycle counter, ignores clken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DATA_WIDTH'(1);
        end
    end

    // Memory-mapped output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_q <= '0;
        end else if (bus.clken && bus.MemWriteInMEM && is_io) begin
            io_q <= bus.RofRtInMEM;
        end
    end

    // WB pipeline registers; register reads capture the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q       <= '0;
            mtr_q       <= 1'b0;
            rw_q        <= 1'b0;
            wreg_q      <= '0;
            rd_sel_q    <= RdReg;
            reg_rdata_q <= '0;
        end else if (bus.clken) begin
            alu_q       <= bus.ALUResultInMEM;
            mtr_q       <= bus.MemToRegInMEM;
            rw_q        <= bus.RegWriteInMEM;
            wreg_q      <= bus.WriteRegInMEM;
            rd_sel_q    <= is_ram ? RdRam : RdReg;
            reg_rdata_q <= is_io ? io_q : cnt_q;
        end
    end

    // Load data mux; the RAM port holds its value while stalled.
    always_comb begin
        mem_data = reg_rdata_q;
        if (rd_sel_q == RdRam) begin
            mem_data = ram_rdata;
        end
    end

    assign bus.MEMMEMBypassDataOutEXE = bus.ALUResultInMEM;
    assign bus.ALUResultOutWB         = alu_q;
    assign bus.MemDataOutWB           = mem_data;
    assign bus.MemToRegOutWB          = mtr_q;
    assign bus.RegWriteOutWB          = rw_q;
    assign bus.WriteRegOutWB          = wreg_q;
    assign bus.IOPortOut              = io_q;
    assign bus.CycleCountOut          = cnt_q;

endmodule

// File: tb/tb_dcr_memory.sv
// Scoreboard bench for the MEM stage: stimulus pushes expected WB results, a monitor pops them.
module tb_dcr_memory;
    import dcr_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        chk_mem;
        logic        mtr;
        logic        rw;
        logic [4:0]  wreg;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    exp_t  sb[$];
    exp_t  mon_e;
    int    errors = 0;
    int    checks = 0;
    logic  pending = 1'b0;
    word_t cyc_exp;

    always #5 clk = ~clk;

    dcr_memory_if bus ();

    dcr_memory dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference cycle count.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc_exp <= '0;
        else     cyc_exp <= cyc_exp + 32'd1;
    end

    // An issued instruction reaches WB at each enabled edge outside reset.
    always @(posedge clk) pending <= bus.clken && !rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare WB outputs against the oldest expected entry.
    always @(negedge clk) begin
        if (pending && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: actual=empty required=entry");
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("op%0d_alu", mon_e.id), bus.ALUResultOutWB, mon_e.alu);
                check($sformatf("op%0d_mtr", mon_e.id), 32'(bus.MemToRegOutWB), 32'(mon_e.mtr));
                check($sformatf("op%0d_rw", mon_e.id), 32'(bus.RegWriteOutWB), 32'(mon_e.rw));
                check($sformatf("op%0d_wreg", mon_e.id), 32'(bus.WriteRegOutWB),
                      32'(mon_e.wreg));
                if (mon_e.chk_mem) begin
                    check($sformatf("op%0d_mem", mon_e.id), bus.MemDataOutWB, mon_e.mem);
                end
            end
        end
    end

    task automatic issue(input int id, input logic [31:0] alu, input logic [7:0] addr,
                         input logic [31:0] rt, input logic mw, input logic mtr,
                         input logic rw, input logic [4:0] wreg, input logic chk_mem,
                         input logic [31:0] exp_mem);
        exp_t e;
        bus.clken          = 1'b1;
        bus.ALUResultInMEM = alu;
        bus.ALUAddrInMEM   = addr;
        bus.RofRtInMEM     = rt;
        bus.MemWriteInMEM  = mw;
        bus.MemToRegInMEM  = mtr;
        bus.RegWriteInMEM  = rw;
        bus.WriteRegInMEM  = wreg;
        e.id      = id;
        e.alu     = alu;
        e.mem     = exp_mem;
        e.chk_mem = chk_mem;
        e.mtr     = mtr;
        e.rw      = rw;
        e.wreg    = wreg;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu"}, bus.ALUResultOutWB, 32'h0);
        check({tag, "_mem"}, bus.MemDataOutWB, 32'h0);
        check({tag, "_mtr"}, 32'(bus.MemToRegOutWB), 32'h0);
        check({tag, "_rw"}, 32'(bus.RegWriteOutWB), 32'h0);
        check({tag, "_wreg"}, 32'(bus.WriteRegOutWB), 32'h0);
        check({tag, "_io"}, bus.IOPortOut, 32'h0);
        check({tag, "_cnt"}, bus.CycleCountOut, 32'h0);
    endtask

    initial begin
        bus.clken          = 1'b0;
        bus.ALUResultInMEM = '0;
        bus.ALUAddrInMEM   = '0;
        bus.RofRtInMEM     = '0;
        bus.MemWriteInMEM  = 1'b0;
        bus.MemToRegInMEM  = 1'b0;
        bus.RegWriteInMEM  = 1'b0;
        bus.WriteRegInMEM  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("cnt_after_reset_%0d", i), bus.CycleCountOut, 32'(i));
        end

        // Store then load.
        issue(1, 32'h100, 8'h10, 32'hDEADBEEF, 1, 0, 0, 5'd0, 0, 32'h0);
        issue(2, 32'h10, 8'h10, 32'h0, 0, 1, 1, 5'd5, 1, 32'hDEADBEEF);
        // Read-before-write on RAM.
        issue(3, 32'h20, 8'h20, 32'h1111, 1, 0, 0, 5'd0, 0, 32'h0);
        issue(4, 32'h20, 8'h20, 32'h2222, 1, 1, 1, 5'd6, 1, 32'h1111);
        issue(5, 32'h20, 8'h20, 32'h0, 0, 1, 1, 5'd7, 1, 32'h2222);
        // IO register store/load, including read-before-write.
        issue(6, 32'hFF, 8'hFF, 32'hA5, 1, 0, 0, 5'd0, 1, 32'h0);
        check("io_after_store", bus.IOPortOut, 32'hA5);
        issue(7, 32'hFF, 8'hFF, 32'h0, 0, 1, 1, 5'd8, 1, 32'hA5);
        issue(8, 32'hFF, 8'hFF, 32'h5A, 1, 1, 1, 5'd9, 1, 32'hA5);
        check("io_after_rbw_store", bus.IOPortOut, 32'h5A);
        // Counter address: reads pre-edge count, store ignored.
        issue(9, 32'hFE, 8'hFE, 32'h1234, 1, 1, 1, 5'd10, 1, cyc_exp);
        check("cnt_ignores_store", bus.CycleCountOut, cyc_exp);
        check("io_unaffected", bus.IOPortOut, 32'h5A);
        issue(10, 32'h30, 8'h30, 32'h77, 1, 0, 0, 5'd0, 0, 32'h0);
        issue(11, 32'hAA, 8'h10, 32'h0, 0, 1, 1, 5'd3, 1, 32'hDEADBEEF);

        // Stall with a store presented for three edges.
        bus.clken          = 1'b0;
        bus.ALUResultInMEM = 32'h0000ABCD;
        bus.ALUAddrInMEM   = 8'h30;
        bus.RofRtInMEM     = 32'h55;
        bus.MemWriteInMEM  = 1'b1;
        bus.MemToRegInMEM  = 1'b1;
        bus.RegWriteInMEM  = 1'b1;
        bus.WriteRegInMEM  = 5'd9;
        #1;
        check("bypass_stalled", bus.MEMMEMBypassDataOutEXE, 32'h0000ABCD);
        repeat (3) @(posedge clk);
        #1;
        check("stall_cnt", bus.CycleCountOut, cyc_exp);
        check("stall_alu", bus.ALUResultOutWB, 32'hAA);
        check("stall_mem", bus.MemDataOutWB, 32'hDEADBEEF);
        check("stall_wreg", 32'(bus.WriteRegOutWB), 32'd3);
        check("stall_mtr", 32'(bus.MemToRegOutWB), 32'd1);
        check("stall_rw", 32'(bus.RegWriteOutWB), 32'd1);

        bus.clken          = 1'b1;
        bus.ALUResultInMEM = 32'h00001357;
        #1;
        check("bypass_enabled", bus.MEMMEMBypassDataOutEXE, 32'h00001357);
        // Stalled store must not have landed.
        issue(12, 32'h0000ABCD, 8'h30, 32'h0, 0, 1, 1, 5'd4, 1, 32'h77);

        // Mid-cycle reset with a store in flight.
        @(negedge clk);
        #1;
        bus.clken         = 1'b1;
        bus.ALUAddrInMEM  = 8'h10;
        bus.RofRtInMEM    = 32'h00000BAD;
        bus.MemWriteInMEM = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(13, 32'h10, 8'h10, 32'h0, 0, 1, 1, 5'd2, 1, 32'hDEADBEEF);
        check("cnt_after_midreset", bus.CycleCountOut, 32'd1);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcr_memory.md
Name: dcr_memory

Overview:
- MEM pipeline stage; consumes the EXE stage outputs: ALU result, 8-bit ALU address and forwarded Rt store data.
- Performs data-memory loads and stores against an internal 256x32 synchronous data RAM.
- Provides two memory-mapped registers: an output port and a free-running cycle counter.
- Supplies the MEM-to-EXE bypass value and registers all WB-bound signals.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 8, word address width; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clken  input  1  pipeline advance enable; 0 = stall.
- ALUResultInMEM  input  32  ALU result from EXE.
- ALUAddrInMEM  input  8  word address for load/store.
- RofRtInMEM  input  32  store data.
- MemWriteInMEM  input  1  store request.
- MemToRegInMEM  input  1  load; WB selects memory data.
- RegWriteInMEM  input  1  instruction writes the register file.
- WriteRegInMEM  input  5  destination register.
- MEMMEMBypassDataOutEXE  output  32  bypass value to EXE operand muxes.
- ALUResultOutWB  output  32  registered ALU result.
- MemDataOutWB  output  32  load data, valid in the WB cycle.
- MemToRegOutWB  output  1  registered MemToRegInMEM.
- RegWriteOutWB  output  1  registered RegWriteInMEM.
- WriteRegOutWB  output  5  registered WriteRegInMEM.
- IOPortOut  output  32  memory-mapped output register.
- CycleCountOut  output  32  free-running cycle counter.

Behaviour:
- Clock and reset: clk; rst is asynchronous, active-high.
- Reset values:
  - All WB outputs, IOPortOut and CycleCountOut reset to 0.
  - RAM contents are not reset.
  - rst asserted mid-operation clears the registers immediately. A store in flight that cycle is dropped.
- Bypass: MEMMEMBypassDataOutEXE = ALUResultInMEM, combinational, zero latency, independent of clken.
- Address map:
  - 0x00-0xFD: RAM.
  - 0xFE (CYCLE_CNT_ADDR): read-only counter; writes are ignored.
  - 0xFF (IO_PORT_ADDR): IOPortOut register, read/write.
  - RAM entries 0xFE/0xFF exist but are never written or read.
- Store:
  - Occurs on a rising edge when clken=1 and MemWriteInMEM=1.
  - Writes RofRtInMEM to the RAM or IO register per the address.
  - clken=0 suppresses the store completely. A stalled store is not repeated later unless it is re-presented.
- Load:
  - Synchronous read at the same edge, one-cycle latency.
  - MemDataOutWB holds the data addressed in the MEM cycle, updated only when clken=1.
  - Reads are unconditional (the address is always sampled). The WB stage uses MemToRegOutWB to qualify the data.
- Counter read returns the CycleCountOut value before the edge.
- Same-address read and write in one cycle: read-before-write. MemDataOutWB returns the old value, for RAM and for the IO register alike.
- WB pipeline registers (ALUResultOutWB, MemToRegOutWB, RegWriteOutWB, WriteRegOutWB, MemDataOutWB) load when clken=1 and hold when clken=0.
- Cycle counter:
  - Increments by 1 every clock, regardless of clken.
  - Wraps 0xFFFFFFFF -> 0 with no flag.
- MemWriteInMEM and MemToRegInMEM both 1 is legal. Result: read-before-write plus the store.
- No handshake to the core beyond clken; the stage never stalls itself.

Decomposition:
- Shared package dcr_pkg:
  - IO_PORT_ADDR = 8'hFF.
  - CYCLE_CNT_ADDR = 8'hFE.
  - DMEM_DEPTH = 256.
  - typedef word_t (logic [31:0]).
  - typedef dmem_addr_t (logic [7:0]).
- Sub-module dcr_dmem:
  - Single-port synchronous RAM with write enable, read enable and read-before-write.
  - No reset on the array.
- Top level holds address decode, IO register, counter, read-data mux and WB registers.

Test Plan:
- Reset: rst=1 for 2 cycles then 0 -> all WB outputs, IOPortOut = 0; CycleCountOut = 0 then increments 1,2,3 on following edges.
- Store/load: store 0xDEADBEEF to 0x10, next cycle load 0x10 with MemToReg=1, RegWrite=1, WriteReg=5 -> one cycle later MemDataOutWB = 0xDEADBEEF, MemToRegOutWB=1, RegWriteOutWB=1, WriteRegOutWB=5.
- Read-before-write: 0x20 holds 0x1111; same cycle store 0x2222 and load 0x20 -> MemDataOutWB=0x1111; a later load of 0x20 returns 0x2222.
- Memory-mapped registers:
  - Store 0x000000A5 to 0xFF -> IOPortOut=0xA5 after the edge; load 0xFF returns 0xA5.
  - Store 0x1234 to 0xFE -> counter unaffected; RAM[0xFE] unaffected.
- Stall: hold clken=0 for 3 cycles with a store of 0x55 to 0x30 presented -> WB outputs frozen, RAM[0x30] unchanged, counter still advances by 3.
- Bypass: ALUResultInMEM=0x0000ABCD -> MEMMEMBypassDataOutEXE=0x0000ABCD in the same cycle, with clken=0 and with clken=1.
